// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes and flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'b0000,
    COND_EQ = 4'b0001,
    COND_NE = 4'b0010,
    COND_LT = 4'b0011,
    COND_GE = 4'b0100,
    COND_GT = 4'b0101,
    COND_LE = 4'b0110,
    COND_MI = 4'b0111,
    COND_PL = 4'b1000,
    COND_VS = 4'b1001,
    COND_VC = 4'b1010
  } cond_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 3;

  localparam logic [3:0] FLAGS_RST = 4'b0000;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator; codes outside the enum are never taken.
module cond_eval
  import cpu_pkg::*;
(
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic z, v, s, lt;
  logic unused_rsvd_flag;

  assign z  = flags_i[FLAG_Z];
  assign v  = flags_i[FLAG_V];
  assign s  = flags_i[FLAG_S];
  assign lt = s ^ v;
  assign unused_rsvd_flag = flags_i[2];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_AL: taken_o = 1'b1;
      COND_EQ: taken_o = z;
      COND_NE: taken_o = ~z;
      COND_LT: taken_o = lt;
      COND_GE: taken_o = ~lt;
      COND_GT: taken_o = ~z & ~lt;
      COND_LE: taken_o = z | lt;
      COND_MI: taken_o = s;
      COND_PL: taken_o = ~s;
      COND_VS: taken_o = v;
      COND_VC: taken_o = ~v;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register: captures ALU result, owns the flags register and
// resolves conditional branches against the pre-update flags.
module ex_wb_stage
  import cpu_pkg::*;
#(
  parameter int N  = 8,
  parameter int RA = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  alu_result,
  input  logic [3:0]    alu_flags,
  input  logic [RA-1:0] rd_in,
  input  logic          reg_we_in,
  input  logic          set_flags_in,
  input  logic          is_branch_in,
  input  logic [3:0]    cond_in,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [N-1:0]  result_out,
  output logic [RA-1:0] rd_out,
  output logic          reg_we_out,
  output logic          branch_taken,
  output logic [3:0]    flags_q
);

  logic          valid_q, valid_d;
  logic [N-1:0]  res_q, res_d;
  logic [RA-1:0] rd_q, rd_d;
  logic          we_q, we_d;
  logic          br_q, br_d;
  logic [3:0]    flg_q, flg_d;
  logic          taken;
  logic          unused_rsvd_flag;

  assign unused_rsvd_flag = alu_flags[2];

  // Evaluated on the current (old) flags: no same-cycle bypass of an update.
  cond_eval u_cond (
    .cond_i (cond_t'(cond_in)),
    .flags_i(flg_q),
    .taken_o(taken)
  );

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    rd_d    = rd_q;
    we_d    = we_q;
    br_d    = br_q;
    flg_d   = flg_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      br_d    = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      res_d   = alu_result;
      rd_d    = rd_in;
      we_d    = in_valid & reg_we_in;
      br_d    = in_valid & is_branch_in & taken;
      if (in_valid && set_flags_in)
        flg_d = {alu_flags[3], 1'b0, alu_flags[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
      flg_q   <= FLAGS_RST;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      br_q    <= br_d;
      flg_q   <= flg_d;
    end
  end

  assign out_valid    = valid_q;
  assign result_out   = res_q;
  assign rd_out       = rd_q;
  assign reg_we_out   = we_q;
  assign branch_taken = br_q;
  assign flags_q      = flg_q;

endmodule
